// File: rtl/div_by_n_serial.sv
// Serial MSB-first divisibility checker: keeps the frame value mod D bit by bit.
// Optional running divisibility flag is enabled by defining DIV_BY_N_SERIAL_LIVE_EN.
module div_by_n_serial #(
  parameter int DIV_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             res,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             bit_valid,
  input  logic             bit_number,
  input  logic             bit_last,
  output logic             bit_ready,
  output logic             done,
  output logic             divl,
  output logic [DIV_W-1:0] rem,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             err,
  output logic             divl_live
);

  typedef enum logic [2:0] {S_UNCFG, S_IDLE, S_RUN, S_REPORT, S_ERR} state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_d, w_d_nxt;
  logic [DIV_W-1:0] r_rem, w_rem_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic             w_load_acc;
  logic             w_bit_acc;
  logic [DIV_W-1:0] w_rem_base;
  logic [DIV_W:0]   w_t;
  logic [DIV_W-1:0] w_rem_step;
  logic [CNT_W-1:0] w_cnt_base;
  logic [CNT_W-1:0] w_cnt_step;

  assign bit_ready  = (r_state == S_IDLE) || (r_state == S_RUN);
  assign w_load_acc = div_load &&
                      ((r_state == S_UNCFG) || (r_state == S_IDLE) || (r_state == S_ERR));
  // A reconfiguration in IDLE wins over a bit offered in the same cycle.
  assign w_bit_acc  = bit_valid && bit_ready && !w_load_acc;

  // The first bit of a frame starts from an empty accumulator.
  assign w_rem_base = (r_state == S_IDLE) ? '0 : r_rem;
  assign w_cnt_base = (r_state == S_IDLE) ? '0 : r_cnt;
  assign w_t        = {w_rem_base, bit_number};
  // rem < D keeps t < 2D, so one conditional subtract restores the invariant.
  assign w_rem_step = (w_t >= {1'b0, r_d}) ? DIV_W'(w_t - {1'b0, r_d}) : w_t[DIV_W-1:0];
  assign w_cnt_step = (w_cnt_base == '1) ? w_cnt_base : w_cnt_base + CNT_W'(1);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_d_nxt     = r_d;
    w_rem_nxt   = r_rem;
    w_cnt_nxt   = r_cnt;
    if (w_load_acc) begin
      w_d_nxt = div_value;
      if (div_value == '0) begin
        w_state_nxt = S_ERR;
      end else begin
        w_state_nxt = S_IDLE;
        w_rem_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    end else if (w_bit_acc) begin
      w_rem_nxt   = w_rem_step;
      w_cnt_nxt   = w_cnt_step;
      w_state_nxt = bit_last ? S_REPORT : S_RUN;
    end else if (r_state == S_REPORT) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (res) begin
      r_state <= S_UNCFG;
      r_d     <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_d     <= w_d_nxt;
      r_rem   <= w_rem_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign done    = (r_state == S_REPORT);
  assign divl    = done && (r_rem == '0);
  assign rem     = r_rem;
  assign bit_cnt = r_cnt;
  assign err     = (r_state == S_ERR);

`ifdef DIV_BY_N_SERIAL_LIVE_EN
  logic r_live;

  always_ff @(posedge clk) begin
    if (res || w_load_acc) begin
      r_live <= 1'b0;
    end else if (w_bit_acc) begin
      r_live <= (w_rem_step == '0);
    end
  end

  assign divl_live = r_live;
`else
  assign divl_live = 1'b0;
`endif

endmodule

// File: tb/tb_div_by_n_serial.sv
// Scoreboard bench for div_by_n_serial: frame results are queued at stimulus time
// and compared by a monitor whenever done pulses.
module tb_div_by_n_serial;

  localparam int DIV_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             res;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic             bit_valid;
  logic             bit_number;
  logic             bit_last;
  logic             bit_ready;
  logic             done;
  logic             divl;
  logic [DIV_W-1:0] rem;
  logic [CNT_W-1:0] bit_cnt;
  logic             err;
  logic             divl_live;

  typedef struct packed {
    logic             divl;
    logic [DIV_W-1:0] rem;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  div_by_n_serial #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .res       (res),
    .div_load  (div_load),
    .div_value (div_value),
    .bit_valid (bit_valid),
    .bit_number(bit_number),
    .bit_last  (bit_last),
    .bit_ready (bit_ready),
    .done      (done),
    .divl      (divl),
    .rem       (rem),
    .bit_cnt   (bit_cnt),
    .err       (err),
    .divl_live (divl_live)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic int live_exp(input int v);
`ifdef DIV_BY_N_SERIAL_LIVE_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DIV_W-1:0] v);
    div_load  = 1'b1;
    div_value = v;
    tick();
    div_load  = 1'b0;
  endtask

  task automatic pulse_bit(input logic b, input logic last);
    bit_valid  = 1'b1;
    bit_number = b;
    bit_last   = last;
    tick();
    bit_valid  = 1'b0;
    bit_last   = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) pulse_bit(bits[i], i == 0);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL frame_unexpected: got done with divl=%0d rem=%0d cnt=%0d expected no frame",
                   divl, rem, bit_cnt);
        end else begin
          e = q.pop_front();
          if ({divl, rem, bit_cnt} !== e) begin
            failures++;
            $display("FAIL frame_result: got divl=%0d rem=%0d cnt=%0d expected divl=%0d rem=%0d cnt=%0d",
                     divl, rem, bit_cnt, e.divl, e.rem, e.cnt);
          end
        end
      end else if (divl !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL divl_idle: got %0d expected 0", divl);
      end
    end
  end

  initial begin
    res = 1'b1; div_load = 1'b0; div_value = '0;
    bit_valid = 1'b0; bit_number = 1'b0; bit_last = 1'b0;
    repeat (2) tick();
    res = 1'b0;

    // Reset state and ignored bits in UNCFG
    check("rst_bit_ready", bit_ready, 0);
    check("rst_rem", rem, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_err", err, 0);
    check("rst_live", divl_live, 0);
    pulse_bit(1'b1, 1'b1);
    check("uncfg_bit_cnt", bit_cnt, 0);
    check("uncfg_ready", bit_ready, 0);

    // D=3, 110 -> divisible
    load(4'd3);
    check("load3_err", err, 0);
    check("load3_ready", bit_ready, 1);
    q.push_back('{divl: 1'b1, rem: 4'd0, cnt: 4'd3});
    send_frame(32'b110, 3);
    tick();

    // D=3, 111 -> rem 1, with running flag after each bit
    q.push_back('{divl: 1'b0, rem: 4'd1, cnt: 4'd3});
    pulse_bit(1'b1, 1'b0);
    check("live_b1", divl_live, live_exp(0));
    pulse_bit(1'b1, 1'b0);
    check("live_b2", divl_live, live_exp(1));
    pulse_bit(1'b1, 1'b1);
    check("live_b3", divl_live, live_exp(0));
    tick();
    check("idle_hold_rem", rem, 1);
    check("idle_hold_cnt", bit_cnt, 3);

    // D=0 -> error, bits ignored; then D=5, 1010 -> divisible
    load(4'd0);
    check("err_set", err, 1);
    check("err_ready", bit_ready, 0);
    pulse_bit(1'b1, 1'b1);
    check("err_stays", err, 1);
    load(4'd5);
    check("err_clear", err, 0);
    check("load5_rem", rem, 0);
    check("load5_cnt", bit_cnt, 0);
    q.push_back('{divl: 1'b1, rem: 4'd0, cnt: 4'd4});
    send_frame(32'b1010, 4);
    tick();

    // D=7, reset mid-frame with load and bit in the same cycle
    load(4'd7);
    pulse_bit(1'b1, 1'b0);
    pulse_bit(1'b1, 1'b0);
    check("run_rem", rem, 3);
    check("run_cnt", bit_cnt, 2);
    res = 1'b1; div_load = 1'b1; div_value = 4'd2;
    bit_valid = 1'b1; bit_number = 1'b1; bit_last = 1'b1;
    tick();
    res = 1'b0; div_load = 1'b0; bit_valid = 1'b0; bit_last = 1'b0;
    check("mid_rst_ready", bit_ready, 0);
    check("mid_rst_rem", rem, 0);
    check("mid_rst_cnt", bit_cnt, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_live", divl_live, 0);

    // D=7, load of 2 during RUN ignored: 1101=13 -> rem 6
    load(4'd7);
    q.push_back('{divl: 1'b0, rem: 4'd6, cnt: 4'd4});
    pulse_bit(1'b1, 1'b0);
    pulse_bit(1'b1, 1'b0);
    load(4'd2);
    pulse_bit(1'b0, 1'b0);
    pulse_bit(1'b1, 1'b1);
    tick();

    // D=3, twenty ones: counter saturates at 15, value divisible
    load(4'd3);
    q.push_back('{divl: 1'b1, rem: 4'd0, cnt: 4'd15});
    for (int i = 0; i < 20; i++) pulse_bit(1'b1, i == 19);
    tick();

    // D=1: always divisible
    load(4'd1);
    q.push_back('{divl: 1'b1, rem: 4'd0, cnt: 4'd3});
    send_frame(32'b101, 3);
    tick();

    repeat (3) tick();
    check("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_by_n_serial.md
DIV_BY_N_SERIAL -- requirements
Module: div_by_n_serial

Interface
REQ-001 SHALL have parameter DIV_W, default 4, divisor and remainder width in bits (2..16).
REQ-002 SHALL have parameter CNT_W, default 16, frame bit-counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port res  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port div_load  input  1  load strobe for div_value.
REQ-006 SHALL have port div_value  input  DIV_W  divisor D, unsigned.
REQ-007 SHALL have port bit_valid  input  1  bit_number is presented this cycle.
REQ-008 SHALL have port bit_number  input  1  serial data bit, MSB first.
REQ-009 SHALL have port bit_last  input  1  qualifies the final bit of a frame (valid only with bit_valid).
REQ-010 SHALL have port bit_ready  output  1  block accepts a bit this cycle.
REQ-011 SHALL have port done  output  1  one-cycle pulse; frame result valid.
REQ-012 SHALL have port divl  output  1  frame value divisible by D; valid while done=1.
REQ-013 SHALL have port rem  output  DIV_W  running/final remainder.
REQ-014 SHALL have port bit_cnt  output  CNT_W  bits accepted in current/last frame.
REQ-015 SHALL have port err  output  1  divisor invalid (D=0).
REQ-016 SHALL have port divl_live  output  1  running divisibility flag (see Configuration).

Function
REQ-017 SHALL implement states UNCFG, IDLE, RUN, REPORT, ERR.
REQ-018 SHALL accept a bit only when bit_valid=1 and bit_ready=1; bit_ready=1 in IDLE and RUN only.
REQ-019 SHALL accept div_load only in UNCFG, IDLE, ERR; div_load in RUN/REPORT ignored, D unchanged.
REQ-020 SHALL on accepted load: D=0 -> ERR, err=1; D>=1 -> IDLE, err=0, rem=0, bit_cnt=0.
REQ-021 SHALL on every accepted bit compute t=2*rem+bit in DIV_W+1 bits and set rem=t-D if t>=D else t (single conditional subtract; rem<D invariant).
REQ-022 SHALL on first bit in IDLE restart accumulation from rem=0, bit_cnt=0 (i.e. rem=(bit mod D), bit_cnt=1), move to RUN unless bit_last.
REQ-023 SHALL on accepted bit with bit_last=1 (IDLE or RUN) move to REPORT next cycle.
REQ-024 SHALL in REPORT assert done=1 for exactly one cycle, divl=(rem==0), hold rem and bit_cnt, then go IDLE.
REQ-025 SHALL drive divl=0 whenever done=0.
REQ-026 SHALL increment bit_cnt per accepted bit, saturating at all-ones (no wrap); rem continues updating after saturation.
REQ-027 SHALL keep rem and bit_cnt from the last frame visible in IDLE until the next frame's first bit.
REQ-028 SHALL ignore bit_valid in UNCFG, ERR, REPORT (no state change).
REQ-029 SHALL treat D=1 as valid: every frame reports divl=1, rem=0.

Reset
REQ-030 SHALL on res=1 at a clock edge enter UNCFG, clearing D, rem, bit_cnt, done, divl, err, divl_live to 0 and bit_ready to 0, regardless of state (incl. mid-frame).
REQ-031 SHALL give res priority over div_load and bit_valid in the same cycle.

Configuration
REQ-032 SHALL use macro DIV_BY_N_SERIAL_LIVE_EN: defined -> divl_live is registered (rem==0) updated in the cycle after each accepted bit, 0 in UNCFG/ERR; undefined -> divl_live tied to constant 0, no live-flag logic.

Verification
REQ-033 SHALL cover: load D=3; bits 1,1,0 (last on 3rd) -> done pulse, divl=1, rem=0, bit_cnt=3.
REQ-034 SHALL cover: D=3; bits 1,1,1 -> done, divl=0, rem=1; live build: divl_live 0,1,0 after bits 1,2,3.
REQ-035 SHALL cover: load D=0 -> err=1, bit_ready=0, bits ignored; then load D=5 -> err=0, bits 1,0,1,0 (10) -> divl=1, rem=0.
REQ-036 SHALL cover: D=7, res=1 after 2 bits of a frame -> all outputs 0, state UNCFG; div_load during RUN (D=2) ignored, frame still reported mod 7.
REQ-037 SHALL cover: CNT_W=4, D=3, 20 bits of 1 -> bit_cnt=15 saturated, rem=(2^20-1) mod 3=0, divl=1.
